// File: rtl/decode_pkg.sv
// Shared decode types: opcodes, imm_gen format codes, load-extension codes and the
// registered bundle carried by the inst_decode skid buffer.
package decode_pkg;

  localparam int BUNDLE_XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Format codes understood by imm_gen; RSV codes are produced by other decoders
  typedef enum logic [3:0] {
    IMM_NONE = 4'd0, IMM_RSV1 = 4'd1, IMM_RSV2 = 4'd2, IMM_I = 4'd3, IMM_RSV4 = 4'd4,
    IMM_RSV5 = 4'd5, IMM_S = 4'd6, IMM_B = 4'd7, IMM_J = 4'd8, IMM_U = 4'd9
  } imm_sel_e;

  typedef enum logic [3:0] {
    LD_EXT_B = 4'd0, LD_EXT_H = 4'd1, LD_EXT_W = 4'd2, LD_EXT_BU = 4'd4, LD_EXT_HU = 4'd5
  } ld_ext_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [BUNDLE_XLEN-1:0] inst;
    logic [BUNDLE_XLEN-1:0] pc;
    logic [3:0]             imm_sel;
    logic [3:0]             ld_ext_sel;
    logic                   uses_imm;
    logic                   illegal;
  } bundle_t;

endpackage

// File: rtl/inst_decode_logic.sv
// Pure combinational opcode/funct3 decode. The illegal flag is only produced when
// INST_DECODE_ILLEGAL_EN is defined; otherwise it is tied low.
module inst_decode_logic
  import decode_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [3:0] imm_sel,
  output logic [3:0] ld_ext_sel,
  output logic       uses_imm,
  output logic       illegal
);

  always_comb begin
    imm_sel    = IMM_I;
    ld_ext_sel = LD_EXT_W;
    uses_imm   = 1'b1;
    illegal    = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        case (funct3)
          3'b000:  ld_ext_sel = LD_EXT_B;
          3'b001:  ld_ext_sel = LD_EXT_H;
          3'b010:  ld_ext_sel = LD_EXT_W;
          3'b100:  ld_ext_sel = LD_EXT_BU;
          3'b101:  ld_ext_sel = LD_EXT_HU;
          default: illegal    = 1'b1;
        endcase
      end
      OPC_OP_IMM: ;
      OPC_JALR:   illegal = (funct3 != 3'b000);
      OPC_STORE: begin
        imm_sel = IMM_S;
        illegal = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        imm_sel = IMM_B;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL:             imm_sel  = IMM_J;
      OPC_LUI, OPC_AUIPC:  imm_sel  = IMM_U;
      OPC_OP:              uses_imm = 1'b0;
      default:             illegal  = 1'b1;
    endcase
`ifdef INST_DECODE_ILLEGAL_EN
    // Illegal encodings still flow, but with a neutral decode
    if (illegal) begin
      imm_sel    = IMM_I;
      ld_ext_sel = LD_EXT_W;
      uses_imm   = 1'b0;
    end
`else
    illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/inst_decode.sv
// Decode stage with a two-entry skid buffer in front of imm_gen/execute.
// Define INST_DECODE_ILLEGAL_EN to add the registered out_illegal output.
//   state     | meaning
//   BUF_EMPTY | main invalid
//   BUF_ONE   | main valid, skid invalid
//   BUF_FULL  | main and skid valid, in_ready low
module inst_decode
  import decode_pkg::*;
#(
  parameter int XLEN = BUNDLE_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_imm_sel,
  output logic [3:0]      out_ld_ext_sel,
  output logic            out_uses_imm
`ifdef INST_DECODE_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  buf_state_e state_q, state_d;
  bundle_t    main_q, main_d;
  bundle_t    skid_q, skid_d;
  bundle_t    new_bundle;
  logic       accept, handoff;

  inst_decode_logic u_logic (
    .opcode     (in_inst[6:0]),
    .funct3     (in_inst[14:12]),
    .imm_sel    (new_bundle.imm_sel),
    .ld_ext_sel (new_bundle.ld_ext_sel),
    .uses_imm   (new_bundle.uses_imm),
    .illegal    (new_bundle.illegal)
  );

  assign new_bundle.inst = in_inst;
  assign new_bundle.pc   = in_pc;

  // in_ready is decoded straight from the state flops, never from out_ready
  assign in_ready  = (state_q != BUF_FULL);
  assign out_valid = (state_q != BUF_EMPTY);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            main_d  = new_bundle;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && handoff) begin
            main_d = new_bundle;
          end else if (accept) begin
            skid_d  = new_bundle;
            state_d = BUF_FULL;
          end else if (handoff) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (handoff) begin
            main_d  = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_inst       = main_q.inst;
  assign out_pc         = main_q.pc;
  assign out_imm_sel    = main_q.imm_sel;
  assign out_ld_ext_sel = main_q.ld_ext_sel;
  // An illegal bundle never consumes an immediate; redundant with the decode
  assign out_uses_imm   = main_q.uses_imm & ~main_q.illegal;
`ifdef INST_DECODE_ILLEGAL_EN
  assign out_illegal    = main_q.illegal;
`endif

endmodule

// File: tb/tb_inst_decode.sv
// Directed self-checking bench for inst_decode: decode table, skid buffer
// backpressure, flush and asynchronous reset.
module tb_inst_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [3:0]  out_imm_sel;
  logic [3:0]  out_ld_ext_sel;
  logic        out_uses_imm;
`ifdef INST_DECODE_ILLEGAL_EN
  logic        out_illegal;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_decode #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_imm_sel    (out_imm_sel),
    .out_ld_ext_sel (out_ld_ext_sel),
    .out_uses_imm   (out_uses_imm)
`ifdef INST_DECODE_ILLEGAL_EN
    ,
    .out_illegal    (out_illegal)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, take one edge, check the resulting main entry
  task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [3:0] sel, input logic [3:0] ld, input logic uimm);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    step();
    check("send_valid", {31'd0, out_valid}, 32'd1);
    check("send_inst", out_inst, inst);
    check("send_pc", out_pc, pc);
    check("send_imm_sel", {28'd0, out_imm_sel}, {28'd0, sel});
    check("send_ld_ext", {28'd0, out_ld_ext_sel}, {28'd0, ld});
    check("send_uses_imm", {31'd0, out_uses_imm}, {31'd0, uimm});
  endtask

  logic [2:0] ld_f3  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [3:0] ld_exp [5] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_imm_sel", {28'd0, out_imm_sel}, 32'd0);
    check("rst_ld_ext", {28'd0, out_ld_ext_sel}, 32'd0);
    check("rst_uses_imm", {31'd0, out_uses_imm}, 32'd0);
`ifdef INST_DECODE_ILLEGAL_EN
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
`endif
    rst = 1'b0;
    step();

    // Streaming, one per cycle
    out_ready = 1'b1;
    send(32'h00500093, 32'h00001000, 4'd3, 4'd2, 1'b1);
    send(32'h00112223, 32'h00001004, 4'd6, 4'd2, 1'b1);
    send(32'hFE000EE3, 32'h00001008, 4'd7, 4'd2, 1'b1);
    send(32'h0000006F, 32'h0000100C, 4'd8, 4'd2, 1'b1);
    send(32'h12345037, 32'h00001010, 4'd9, 4'd2, 1'b1);
    check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // LOAD funct3 sweep
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ld_inst;
      ld_inst = 32'h00000003 | ({29'd0, ld_f3[i]} << 12);
      send(ld_inst, 32'h00002000 + 32'(i * 4), 4'd3, ld_exp[i], 1'b1);
    end
    in_valid = 1'b0;
    step();

    // Backpressure: three presented, two accepted
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h100;
    step();
    check("bp1_valid", {31'd0, out_valid}, 32'd1);
    check("bp1_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp1_pc", out_pc, 32'h100);
    in_inst = 32'h00112223; in_pc = 32'h104;
    step();
    check("bp2_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp2_pc", out_pc, 32'h100);
    in_inst = 32'hFE000EE3; in_pc = 32'h108;
    step();
    check("bp3_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp3_pc", out_pc, 32'h100);
    check("bp3_imm_sel", {28'd0, out_imm_sel}, 32'd3);
    out_ready = 1'b1;
    step();
    check("bp4_pc", out_pc, 32'h104);
    check("bp4_imm_sel", {28'd0, out_imm_sel}, 32'd6);
    check("bp4_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("bp5_pc", out_pc, 32'h108);
    check("bp5_imm_sel", {28'd0, out_imm_sel}, 32'd7);
    in_valid = 1'b0;
    step();
    check("bp6_valid", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with input offered, then while ONE with an accept
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h200;
    step();
    in_pc = 32'h204;
    step();
    check("fl_full", {31'd0, in_ready}, 32'd0);
    in_pc = 32'h208; flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl1_valid", {31'd0, out_valid}, 32'd0);
    check("fl1_in_ready", {31'd0, in_ready}, 32'd1);
    in_pc = 32'h20C;
    step();
    check("fl2_pc", out_pc, 32'h20C);
    in_pc = 32'h210; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl3_valid", {31'd0, out_valid}, 32'd0);
    check("fl3_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_ghost", {31'd0, out_valid}, 32'd0);
    end
    send(32'h0000006F, 32'h300, 4'd8, 4'd2, 1'b1);
    in_valid = 1'b0;
    step();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h12345037; in_pc = 32'h400;
    step();
    in_pc = 32'h404;
    step();
    in_valid = 1'b0;
    check("ar_full", {31'd0, in_ready}, 32'd0);
    #3 rst = 1'b1;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    check("ar_out_inst", out_inst, 32'd0);
    check("ar_out_pc", out_pc, 32'd0);
    check("ar_imm_sel", {28'd0, out_imm_sel}, 32'd0);
    check("ar_ld_ext", {28'd0, out_ld_ext_sel}, 32'd0);
    check("ar_uses_imm", {31'd0, out_uses_imm}, 32'd0);
    #1 rst = 1'b0;
    step();
    check("ar_after_valid", {31'd0, out_valid}, 32'd0);

    // Unlisted encodings and OP
    out_ready = 1'b1;
`ifdef INST_DECODE_ILLEGAL_EN
    send(32'h0000007F, 32'h500, 4'd3, 4'd2, 1'b0);
    check("ill_opcode", {31'd0, out_illegal}, 32'd1);
    send(32'h00003003, 32'h504, 4'd3, 4'd2, 1'b0);
    check("ill_load011", {31'd0, out_illegal}, 32'd1);
    send(32'h002081B3, 32'h508, 4'd3, 4'd2, 1'b0);
    check("ill_add", {31'd0, out_illegal}, 32'd0);
    send(32'h00004023, 32'h50C, 4'd3, 4'd2, 1'b0);
    check("ill_store100", {31'd0, out_illegal}, 32'd1);
    send(32'h00500093, 32'h510, 4'd3, 4'd2, 1'b1);
    check("ill_addi", {31'd0, out_illegal}, 32'd0);
`else
    send(32'h0000007F, 32'h500, 4'd3, 4'd2, 1'b1);
    send(32'h002081B3, 32'h508, 4'd3, 4'd2, 1'b0);
    send(32'h00004023, 32'h50C, 4'd6, 4'd2, 1'b1);
`endif
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
